// File: rtl/y86_bus_pkg.sv
// Shared constants, register map and decode type for the y86 bus memory slave.
package y86_bus_pkg;

  // Byte offsets of the MMIO registers relative to IO_BASE
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
  localparam logic [31:0] CYCLE_OFS  = 32'h0000_0008;

  // STATUS register field positions
  localparam int STAT_CNT_LSB   = 0;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;
  localparam int STAT_ERR_BIT   = 11;

  // Address decode result
  typedef enum logic [2:0] {
    REG_RAM,
    REG_TX,
    REG_STATUS,
    REG_CYCLE,
    REG_NONE
  } reg_sel_e;

  // Assemble the STATUS word from its fields; unused upper bits read as zero
  function automatic logic [31:0] pack_status(input logic       err,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: 8] = cnt;
    w[STAT_EMPTY_BIT]    = empty;
    w[STAT_FULL_BIT]     = full;
    w[STAT_OVF_BIT]      = ovf;
    w[STAT_ERR_BIT]      = err;
    return w;
  endfunction

endpackage

// File: rtl/y86_tx_fifo.sv
// Console transmit FIFO: 8-bit entries, power-of-two depth, wrap-bit pointers.
module y86_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pop_ok;
  logic          push_ok;

  // Occupancy flags and accepted push/pop; a push into a full FIFO is taken
  // only when the head leaves in the same cycle, freeing the slot it reuses
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/y86_bus_mem.sv
// Bus-side RAM and MMIO slave for the y86 sequential core: byte-addressed
// wrap-around RAM, console TX FIFO, STATUS register and free-running cycle counter.
module y86_bus_mem
  import y86_bus_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic        bus_RE,
  input  logic        bus_WE,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] byte_idx [4];
  reg_sel_e      sel;

  logic          ram_we;
  logic          tx_push;
  logic          tx_pop;
  logic          err_set;
  logic          ovf_set;
  logic          stat_clr;

  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   ram_word;
  logic [31:0]   status_word;

  // Address decode and the four byte lanes of a word access, wrapping at MEM_BYTES
  always_comb begin
    sel = REG_NONE;
    if (bus_A < 32'(MEM_BYTES))                 sel = REG_RAM;
    else if (bus_A == IO_BASE + TXDATA_OFS)     sel = REG_TX;
    else if (bus_A == IO_BASE + STATUS_OFS)     sel = REG_STATUS;
    else if (bus_A == IO_BASE + CYCLE_OFS)      sel = REG_CYCLE;
    for (int k = 0; k < 4; k++) begin
      byte_idx[k] = bus_A[AW-1:0] + AW'(k);
    end
  end

  // Strobe qualification and next-state for the sticky flags and the counter;
  // a new error or overflow overrides a same-cycle STATUS clear
  always_comb begin
    ram_we   = bus_WE && (sel == REG_RAM);
    tx_push  = bus_WE && (sel == REG_TX);
    stat_clr = bus_WE && (sel == REG_STATUS);
    err_set  = (bus_RE || bus_WE) && (sel == REG_NONE);
    tx_pop   = tx_valid && tx_ready;
    ovf_set  = tx_push && fifo_full && !tx_pop;
    err_d    = err_q;
    ovf_d    = ovf_q;
    if (stat_clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (err_set) err_d = 1'b1;
    if (ovf_set) ovf_d = 1'b1;
    cycle_d = cycle_q + 32'd1;
  end

  // Control state: sticky flags and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // RAM write of all four bytes, little-endian; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        mem[byte_idx[k]] <= bus_wdata[8*k +: 8];
      end
    end
  end

  // Zero-latency read mux; pre-write contents are returned when both strobes are high
  always_comb begin
    ram_word    = {mem[byte_idx[3]], mem[byte_idx[2]], mem[byte_idx[1]], mem[byte_idx[0]]};
    status_word = pack_status(err_q, ovf_q, fifo_full, fifo_empty, 8'(fifo_count));
    bus_rdata   = '0;
    if (bus_RE) begin
      case (sel)
        REG_RAM:    bus_rdata = ram_word;
        REG_STATUS: bus_rdata = status_word;
        REG_CYCLE:  bus_rdata = cycle_q;
        default:    bus_rdata = '0;
      endcase
    end
  end

  y86_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (bus_wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign err      = err_q;

endmodule

// File: tb/tb_y86_bus_mem.sv
// Directed self-checking bench for y86_bus_mem.
module tb_y86_bus_mem;

  localparam int unsigned MEM_BYTES  = 4096;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [31:0] IO_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] A_TX       = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS   = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE    = 32'hFFFF_0008;

  logic        clk;
  logic        rst;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  int checks;
  int failures;

  y86_bus_mem #(
    .MEM_BYTES  (MEM_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IO_BASE    (IO_BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_A     (bus_A),
    .bus_RE    (bus_RE),
    .bus_WE    (bus_WE),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus access helpers: entered and left 1ns after a rising edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_A = a; bus_wdata = d; bus_WE = 1'b1;
    @(posedge clk); #1;
    bus_WE = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_A = a; bus_RE = 1'b1;
    @(negedge clk);
    d = bus_rdata;
    @(posedge clk); #1;
    bus_RE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus_A = A_CYCLE; bus_RE = 1'b0;
    #1;
    checks++;
    if (bus_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata_gated: got %h expected %h", bus_rdata, 32'h0);
    end
    bus_RE = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_cycle0: got %h expected %h", bus_rdata, 32'h0);
    end
    checks++;
    if (tx_valid !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got valid=%b err=%b expected 0 0", tx_valid, err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_rdata !== 32'h1) begin
      failures++; $display("FAIL reset_cycle1: got %h expected %h", bus_rdata, 32'h1);
    end
    bus_RE = 1'b0;
    begin
      logic [31:0] d;
      bus_read(A_STATUS, d);
      checks++;
      if (d !== 32'h0000_0100) begin
        failures++; $display("FAIL reset_status: got %h expected %h", d, 32'h0000_0100);
      end
    end
  endtask

  task automatic test_ram_basic();
    logic [31:0] d;
    bus_write(32'h14, 32'h5566_77EE);
    bus_write(32'h10, 32'h1122_3344);
    bus_read(32'h10, d);
    checks++;
    if (d !== 32'h1122_3344) begin
      failures++; $display("FAIL ram_aligned: got %h expected %h", d, 32'h1122_3344);
    end
    bus_read(32'h11, d);
    checks++;
    if (d !== 32'hEE11_2233) begin
      failures++; $display("FAIL ram_unaligned1: got %h expected %h", d, 32'hEE11_2233);
    end
    bus_read(32'h12, d);
    checks++;
    if (d !== 32'h77EE_1122) begin
      failures++; $display("FAIL ram_unaligned2: got %h expected %h", d, 32'h77EE_1122);
    end
  endtask

  task automatic test_ram_wrap();
    logic [31:0] d;
    bus_write(MEM_BYTES - 2, 32'hAABB_CCDD);
    bus_read(32'h0, d);
    checks++;
    if (d[15:0] !== 16'hAABB) begin
      failures++; $display("FAIL ram_wrap_low: got %h expected %h", d[15:0], 16'hAABB);
    end
    bus_read(MEM_BYTES - 2, d);
    checks++;
    if (d !== 32'hAABB_CCDD) begin
      failures++; $display("FAIL ram_wrap_read: got %h expected %h", d, 32'hAABB_CCDD);
    end
    bus_read(MEM_BYTES - 1, d);
    checks++;
    if (d[23:0] !== 24'hAABB_CC) begin
      failures++; $display("FAIL ram_wrap_read1: got %h expected %h", d[23:0], 24'hAABBCC);
    end
  endtask

  task automatic test_both_strobes();
    logic [31:0] d;
    bus_A = 32'h10; bus_wdata = 32'hCAFE_BABE; bus_RE = 1'b1; bus_WE = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rdata !== 32'h1122_3344) begin
      failures++; $display("FAIL both_strobes_old: got %h expected %h", bus_rdata, 32'h1122_3344);
    end
    @(posedge clk); #1;
    bus_RE = 1'b0; bus_WE = 1'b0;
    bus_read(32'h10, d);
    checks++;
    if (d !== 32'hCAFE_BABE) begin
      failures++; $display("FAIL both_strobes_new: got %h expected %h", d, 32'hCAFE_BABE);
    end
  endtask

  task automatic test_rdata_gating();
    bus_A = 32'h10; bus_RE = 1'b0;
    #1;
    checks++;
    if (bus_rdata !== 32'h0) begin
      failures++; $display("FAIL gating_low: got %h expected %h", bus_rdata, 32'h0);
    end
    bus_RE = 1'b1;
    #1;
    checks++;
    if (bus_rdata !== 32'hCAFE_BABE) begin
      failures++; $display("FAIL gating_high: got %h expected %h", bus_rdata, 32'hCAFE_BABE);
    end
    @(posedge clk); #1;
    bus_RE = 1'b0;
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    tx_ready = 1'b0;
    bus_A = A_TX; bus_wdata = 32'h41; bus_WE = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_valid_before_push: got %b expected 0", tx_valid);
    end
    @(posedge clk); #1;
    bus_WE = 1'b0;
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++; $display("FAIL tx_valid_after_push: got %b expected 1", tx_valid);
    end
    for (int i = 1; i < 9; i++) bus_write(A_TX, 32'h41 + i);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0608) begin
      failures++; $display("FAIL ovf_status: got %h expected %h", d, 32'h0000_0608);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        failures++;
        $display("FAIL ovf_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_drained_valid: got %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
    bus_write(A_STATUS, 32'h0);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL ovf_cleared: got %h expected %h", d, 32'h0000_0100);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [7:0]  exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_TX, 32'h61 + i);
    tx_ready = 1'b1;
    bus_A = A_TX; bus_wdata = 32'h50; bus_WE = 1'b1;
    @(posedge clk); #1;
    bus_WE = 1'b0; tx_ready = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0208) begin
      failures++; $display("FAIL full_push_pop_status: got %h expected %h", d, 32'h0000_0208);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'(8'h62 + i) : 8'h50;
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        failures++;
        $display("FAIL full_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i, tx_valid, tx_data, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL full_drained_valid: got %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_read(IO_BASE + 32'h20, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL unmapped_rdata: got %h expected %h", d, 32'h0);
    end
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL unmapped_read_err: got %b expected 1", err);
    end
    bus_write(A_STATUS, 32'h0);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_clear: got %b expected 0", err);
    end
    bus_write(32'h0000_2000, 32'h1234_5678);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL unmapped_write_err: got %b expected 1", err);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0900) begin
      failures++; $display("FAIL err_status: got %h expected %h", d, 32'h0000_0900);
    end
    bus_read(A_TX, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL txdata_read: got %h expected %h", d, 32'h0);
    end
    bus_write(A_STATUS, 32'h0);
  endtask

  task automatic test_cycle();
    logic [31:0] c0;
    logic [31:0] c1;
    bus_A = A_CYCLE; bus_RE = 1'b1;
    @(negedge clk);
    c0 = bus_rdata;
    repeat (5) @(posedge clk);
    @(negedge clk);
    c1 = bus_rdata;
    @(posedge clk); #1;
    bus_RE = 1'b0;
    checks++;
    if (c1 - c0 !== 32'd5) begin
      failures++; $display("FAIL cycle_delta: got %0d expected %0d", c1 - c0, 5);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_TX, 32'h70 + i);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      failures++; $display("FAIL mid_status3: got %h expected %h", d, 32'h0000_0003);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_valid: got %b expected 0", tx_valid);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL mid_reset_status: got %h expected %h", d, 32'h0000_0100);
    end
    bus_read(32'h10, d);
    checks++;
    if (d !== 32'hCAFE_BABE) begin
      failures++; $display("FAIL mid_reset_ram: got %h expected %h", d, 32'hCAFE_BABE);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; bus_A = '0; bus_RE = 1'b0; bus_WE = 1'b0; bus_wdata = '0; tx_ready = 1'b0;
    test_reset();
    test_ram_basic();
    test_ram_wrap();
    test_both_strobes();
    test_rdata_gating();
    test_fifo_overflow();
    test_full_push_pop();
    test_unmapped();
    test_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
